// File: rtl/pcs_40g_pkg.sv
// Shared types and defaults for the 40GBASE-R transmit PCS.
// Holds the alignment-marker scheduler state encoding and lane/gap constants.
package pcs_40g_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_AM,
        S_DATA
    } am_sched_state_e;

    localparam int AM_GAP_N_DEF    = 16383;
    localparam int LANE_N_DEF      = 4;
    localparam int INIT_IDLE_N_DEF = 4;
    localparam int AM_LAT_DEF      = 2;

endpackage

// File: rtl/pcs_am_delay.sv
// Marker-select delay line.
// Tracks the encode/scramble pipeline depth so the AM mux hits the right block.
module pcs_am_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);

    logic [LAT-1:0] sr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[LAT-1];

endmodule

// File: rtl/pcs_40g_am_sched.sv
// 40GBASE-R transmit alignment-marker scheduler.
// Forced idle after reset, then one marker slot every AM_GAP_N blocks.
module pcs_40g_am_sched
    import pcs_40g_pkg::*;
#(
    parameter int LANE_N      = LANE_N_DEF,
    parameter int AM_GAP_N    = AM_GAP_N_DEF,
    parameter int CNT_W       = $clog2(AM_GAP_N),
    parameter int INIT_IDLE_N = INIT_IDLE_N_DEF,
    parameter int AM_LAT      = AM_LAT_DEF
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             am_dis_i,
    output logic             ready_o,
    output logic             force_idle_o,
    output logic             am_v_o,
    output logic             am_mux_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    localparam int INIT_W = (INIT_IDLE_N > 1) ? $clog2(INIT_IDLE_N) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_IDLE_N - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(AM_GAP_N - 1);

    generate
        if (AM_LAT < 1 || LANE_N < 1 || INIT_IDLE_N < 1 || AM_GAP_N < 2)
        begin : g_cfg_bad
            $error("pcs_40g_am_sched: unsupported parameter set");
        end
    endgenerate

    am_sched_state_e   state;
    am_sched_state_e   state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic [INIT_W-1:0] init_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ready_nxt;
    logic              idle_nxt;
    logic              amv_nxt;

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= S_INIT;
            init_cnt     <= '0;
            blk_cnt_o    <= '0;
            ready_o      <= 1'b0;
            force_idle_o <= 1'b1;
            am_v_o       <= 1'b0;
        end else begin
            state        <= state_nxt;
            init_cnt     <= init_nxt;
            blk_cnt_o    <= cnt_nxt;
            ready_o      <= ready_nxt;
            force_idle_o <= idle_nxt;
            am_v_o       <= amv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        init_nxt  = init_cnt;
        cnt_nxt   = blk_cnt_o;
        unique case (state)
            S_INIT: begin
                cnt_nxt = '0;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = S_AM;
                    init_nxt  = '0;
                end else begin
                    init_nxt = init_cnt + 1'b1;
                end
            end
            S_AM: begin
                state_nxt = S_DATA;
                cnt_nxt   = '0;
            end
            S_DATA: begin
                // am_dis_i only matters at the wrap; mid-gap changes are ignored.
                if (blk_cnt_o == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (!am_dis_i) begin
                        state_nxt = S_AM;
                    end
                end else begin
                    cnt_nxt = blk_cnt_o + 1'b1;
                end
            end
            default: begin
                state_nxt = S_INIT;
                init_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ready_nxt = 1'b0;
        idle_nxt  = 1'b0;
        amv_nxt   = 1'b0;
        unique case (1'b1)
            (state_nxt == S_AM):   amv_nxt   = 1'b1;
            (state_nxt == S_DATA): ready_nxt = 1'b1;
            default:               idle_nxt  = 1'b1;
        endcase
    end

    pcs_am_delay #(
        .LAT (AM_LAT)
    ) u_am_dly (
        .clk    (clk),
        .nreset (nreset),
        .d      (am_v_o),
        .q      (am_mux_o)
    );

endmodule

// File: tb/tb_pcs_40g_am_sched.sv
// Directed bench for the AM scheduler: small-gap instance plus default instance.
module tb_pcs_40g_am_sched;

    localparam int GAP  = 7;
    localparam int INIT = 3;
    localparam int LAT  = 2;
    localparam int CW   = $clog2(GAP);
    localparam int CW2  = $clog2(16383);

    logic           clk = 1'b0;
    logic           nreset = 1'b0;
    logic           nreset2 = 1'b0;
    logic           am_dis = 1'b0;
    logic           ready, idle, amv, mux;
    logic [CW-1:0]  cnt;
    logic           ready2, idle2, amv2, mux2;
    logic [CW2-1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcs_40g_am_sched #(
        .AM_GAP_N    (GAP),
        .INIT_IDLE_N (INIT),
        .AM_LAT      (LAT)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .am_dis_i     (am_dis),
        .ready_o      (ready),
        .force_idle_o (idle),
        .am_v_o       (amv),
        .am_mux_o     (mux),
        .blk_cnt_o    (cnt)
    );

    pcs_40g_am_sched dut2 (
        .clk          (clk),
        .nreset       (nreset2),
        .am_dis_i     (1'b0),
        .ready_o      (ready2),
        .force_idle_o (idle2),
        .am_v_o       (amv2),
        .am_mux_o     (mux2),
        .blk_cnt_o    (cnt2)
    );

    typedef struct {
        logic dis;
        logic rdy;
        logic idl;
        logic amv;
        logic mux;
        int   cnt;
    } vec_t;

    vec_t tbl [29];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int  n_am, n_rdy, n_mux, n_both, n_idle, last, k0;
        int  mx, per;
        bit  found;

        // dis rdy idl amv mux cnt
        tbl[0]  = '{0, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 1, 1};
        tbl[6]  = '{0, 1, 0, 0, 0, 2};
        tbl[7]  = '{0, 1, 0, 0, 0, 3};
        tbl[8]  = '{0, 1, 0, 0, 0, 4};
        tbl[9]  = '{0, 1, 0, 0, 0, 5};
        tbl[10] = '{0, 1, 0, 0, 0, 6};
        tbl[11] = '{0, 0, 0, 1, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 1, 1};
        tbl[14] = '{0, 1, 0, 0, 0, 2};
        tbl[15] = '{1, 1, 0, 0, 0, 3};
        tbl[16] = '{1, 1, 0, 0, 0, 4};
        tbl[17] = '{1, 1, 0, 0, 0, 5};
        tbl[18] = '{1, 1, 0, 0, 0, 6};
        tbl[19] = '{1, 1, 0, 0, 0, 0};
        tbl[20] = '{0, 1, 0, 0, 0, 1};
        tbl[21] = '{0, 1, 0, 0, 0, 2};
        tbl[22] = '{0, 1, 0, 0, 0, 3};
        tbl[23] = '{0, 1, 0, 0, 0, 4};
        tbl[24] = '{0, 1, 0, 0, 0, 5};
        tbl[25] = '{0, 1, 0, 0, 0, 6};
        tbl[26] = '{0, 0, 0, 1, 0, 0};
        tbl[27] = '{0, 1, 0, 0, 0, 0};
        tbl[28] = '{0, 1, 0, 0, 1, 1};

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready), 0);
        chk("rst_idle", int'(idle), 1);
        chk("rst_amv", int'(amv), 0);
        chk("rst_mux", int'(mux), 0);
        chk("rst_cnt", int'(cnt), 0);

        // Startup, two periods, and a disabled wrap
        nreset = 1'b1;
        for (int k = 0; k < 29; k++) begin
            am_dis = tbl[k].dis;
            chk($sformatf("v%0d_ready", k), int'(ready), int'(tbl[k].rdy));
            chk($sformatf("v%0d_idle", k), int'(idle), int'(tbl[k].idl));
            chk($sformatf("v%0d_amv", k), int'(amv), int'(tbl[k].amv));
            chk($sformatf("v%0d_mux", k), int'(mux), int'(tbl[k].mux));
            chk($sformatf("v%0d_cnt", k), int'(cnt), tbl[k].cnt);
            @(negedge clk);
        end

        // Ten steady-state periods starting on a marker
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (amv) found = 1'b1;
            else @(negedge clk);
        end
        chk("p_find_am", int'(found), 1);
        n_am = 0; n_rdy = 0; n_mux = 0; n_both = 0; n_idle = 0; last = -1;
        for (int i = 0; i < 80; i++) begin
            if (amv) begin
                if (last >= 0) chk($sformatf("p_gap%0d", n_am), i - last, 8);
                last = i;
                n_am++;
            end
            if (ready) n_rdy++;
            if (mux) n_mux++;
            if (ready && amv) n_both++;
            if (idle) n_idle++;
            @(negedge clk);
        end
        chk("p_am_cnt", n_am, 10);
        chk("p_ready_cnt", n_rdy, 70);
        chk("p_mux_cnt", n_mux, 10);
        chk("p_coincide", n_both, 0);
        chk("p_idle_cnt", n_idle, 0);

        // Reset with a marker in the delay line
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (amv) found = 1'b1;
            else @(negedge clk);
        end
        chk("r_find_am", int'(found), 1);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("r_ready", int'(ready), 0);
        chk("r_idle", int'(idle), 1);
        chk("r_amv", int'(amv), 0);
        chk("r_mux0", int'(mux), 0);
        chk("r_cnt", int'(cnt), 0);
        @(negedge clk);
        chk("r_mux1", int'(mux), 0);
        nreset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("r%0d_amv", k), int'(amv), int'(k == 3));
            chk($sformatf("r%0d_mux", k), int'(mux), int'(k == 5));
            chk($sformatf("r%0d_idle", k), int'(idle), int'(k < 3));
            @(negedge clk);
        end

        // Default parameters: full 16384-cycle period
        nreset2 = 1'b1;
        found = 1'b0;
        k0 = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (amv2) begin
                found = 1'b1;
                k0 = i;
            end else begin
                @(negedge clk);
            end
        end
        chk("d_first_am", k0, 4);
        @(negedge clk);
        per = 1; mx = 0; n_rdy = 0; n_mux = 0; n_idle = 0;
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            if (amv2) begin
                found = 1'b1;
            end else begin
                if (int'(cnt2) > mx) mx = int'(cnt2);
                if (ready2) n_rdy++;
                if (mux2) n_mux++;
                if (idle2) n_idle++;
                per++;
                @(negedge clk);
            end
        end
        chk("d_found", int'(found), 1);
        chk("d_period", per, 16384);
        chk("d_cnt_max", mx, 16382);
        chk("d_ready_cnt", n_rdy, 16383);
        chk("d_mux_cnt", n_mux, 1);
        chk("d_idle_cnt", n_idle, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_40g_am_sched.md
Name: pcs_40g_am_sched

Overview:
- Sequencing controller for the 40GBASE-R transmit PCS datapath (4 lanes × 64b blocks).
- Schedules alignment-marker (AM) insertion every AM_GAP_N data blocks per lane.
- Backpressures the MAC through ready_o during marker cycles and holds the datapath in forced-idle after reset.
- Drives a delayed marker-select so the output mux replaces the correct block after the encode/scramble pipeline.

Parameters:
- LANE_N, 4, number of PCS lanes; markers are inserted on all lanes in the same cycle.
- AM_GAP_N, 16383, data blocks per lane between consecutive markers.
- CNT_W, $clog2(AM_GAP_N), block counter width.
- INIT_IDLE_N, 4, cycles of forced idle after reset before the first marker.
- AM_LAT, 2, pipeline depth in cycles from MAC acceptance to the marker mux; must be ≥ 1.

Ports:
- clk, input, 1, PCS transmit clock.
- nreset, input, 1, asynchronous active-low reset.
- am_dis_i, input, 1, marker-insertion disable (test/bring-up); sampled only at counter wrap.
- ready_o, output, 1, MAC inputs presented at this edge are accepted; encoder/scrambler advance enable.
- force_idle_o, output, 1, encoder substitutes idle control blocks on all lanes.
- am_v_o, output, 1, current cycle is a marker slot; aligned with ready_o low.
- am_mux_o, output, 1, am_v_o delayed AM_LAT cycles; selects the AM pattern at the output mux.
- blk_cnt_o, output, CNT_W, current data-block count; debug only.

Behaviour:
- All outputs are registered. Reset values: ready_o=0, force_idle_o=1, am_v_o=0, am_mux_o=0, blk_cnt_o=0, FSM=S_INIT, init counter=0, delay line all 0.
- FSM states are S_INIT, S_AM and S_DATA.
- S_INIT:
  - ready_o=0, force_idle_o=1.
  - Counts INIT_IDLE_N cycles, then moves to S_AM. The first non-idle slot on every lane is always a marker.
- S_AM (exactly 1 cycle):
  - am_v_o=1, ready_o=0, force_idle_o=0, blk_cnt_o=0.
  - Next state is S_DATA.
- S_DATA:
  - ready_o=1, am_v_o=0, force_idle_o=0.
  - blk_cnt_o increments each cycle.
  - When blk_cnt_o==AM_GAP_N-1, blk_cnt_o wraps to 0 on the next cycle, and:
    - if am_dis_i=0: next state is S_AM;
    - if am_dis_i=1: stay in S_DATA, so ready_o stays high with no gap.
- Steady-state period is AM_GAP_N+1 cycles: AM_GAP_N ready cycles plus 1 marker cycle. Exactly one marker slot per lane every AM_GAP_N+1 blocks.
- am_dis_i changes mid-gap have no effect until the next wrap. A marker already in flight in the delay line always completes.
- am_mux_o is a pure AM_LAT-stage shift of am_v_o. am_mux_o ones-count equals am_v_o ones-count, shifted AM_LAT cycles.
- Async reset at any point (including during S_AM or with a marker in the delay line):
  - All state clears immediately and the delay line flushes, so no residual am_mux_o pulse.
  - Sequence restarts in S_INIT.
- ready_o and am_v_o are never both 1. force_idle_o=1 only in S_INIT.
- No combinational input-to-output path.

Decomposition:
- Shared package pcs_40g_pkg holds:
  - FSM state enum am_sched_state_e {S_INIT, S_AM, S_DATA};
  - constants AM_GAP_N_DEF=16383, LANE_N_DEF=4.
- Sub-module pcs_am_delay: parameterised AM_LAT-deep, 1-bit shift register with async active-low clear, used for am_mux_o.

Test Plan (AM_GAP_N=7, INIT_IDLE_N=3, AM_LAT=2 unless noted):
1. Reset release, am_dis_i=0 -> force_idle_o=1 and ready_o=0 for cycles 0-2; am_v_o=1 at cycle 3; ready_o=1 for cycles 4-10; am_v_o=1 at cycle 11; am_mux_o=1 at cycles 5 and 13.
2. Run 10 periods -> exactly 10 am_v_o pulses spaced 8 cycles apart, ready_o high 70 cycles, never coincident with am_v_o.
3. am_dis_i=1 asserted mid-gap (blk_cnt_o=3) -> the following wrap produces no marker, ready_o stays high through blk_cnt_o 6→0. Deassert -> next wrap gives am_v_o=1.
4. nreset pulsed low the cycle after am_v_o=1 -> am_mux_o stays 0 (delay line flushed), FSM back to S_INIT, first marker 3 cycles after release.
5. Default parameters (AM_GAP_N=16383) -> successive am_v_o pulses exactly 16384 cycles apart; blk_cnt_o peaks at 16382.
